// File: rtl/rv32_pkg.sv
// Shared RV32 writeback types: register address width and the queued result entry.
package rv32_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
    logic                  live;
  } wb_entry_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: pipeline result, M-unit valid/ready offer, hazard query, register file port.
// The master drives the pipeline/M-unit/query inputs; the slave is the arbiter.
interface writeback_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic                              pipe_valid;
  logic [rv32_pkg::REG_ADDR_W-1:0]   pipe_rd;
  logic [XLEN-1:0]                   pipe_data;
  logic                              mdu_valid;
  logic                              mdu_ready;
  logic [rv32_pkg::REG_ADDR_W-1:0]   mdu_rd;
  logic [XLEN-1:0]                   mdu_data;
  logic [rv32_pkg::REG_ADDR_W-1:0]   query_rd;
  logic                              query_pending;
  logic [AW:0]                       fifo_count;
  logic                              regWrite;
  logic [rv32_pkg::REG_ADDR_W-1:0]   writeReg;
  logic [XLEN-1:0]                   writeData;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data, query_rd,
    input  mdu_ready, query_pending, fifo_count, regWrite, writeReg, writeData
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data, query_rd,
    output mdu_ready, query_pending, fifo_count, regWrite, writeReg, writeData
  );
endinterface

// File: rtl/wb_pending_queue.sv
// Circular buffer of pending M-unit results with kill-by-rd broadcast and a live-rd lookup.
// Push/pop take effect at the edge; head and query_pending are combinational from current state.
module wb_pending_queue import rv32_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  input  logic [REG_ADDR_W-1:0] query_rd,
  output logic                  query_pending,
  output wb_entry_t             head,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);
  wb_entry_t       mem [DEPTH];
  wb_entry_t       push_q;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   offset [DEPTH];
  logic [DEPTH-1:0] hit;

  // An entry arriving alongside a pipe write to the same rd is already stale.
  always_comb begin
    push_q = push_entry;
    if (kill && push_entry.rd == kill_rd) push_q.live = 1'b0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (kill && mem[i].rd == kill_rd) mem[i].live <= 1'b0;
    end
    if (push) mem[wr_ptr] <= push_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is occupied when its distance from the head is below the occupancy.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset[i] = AW'(i) - rd_ptr;
      hit[i]    = ({1'b0, offset[i]} < count) && mem[i].live && (mem[i].rd == query_rd);
    end
  end

  assign query_pending = (query_rd != '0) && (|hit);
  assign head          = mem[rd_ptr];
  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0);
endmodule

// File: rtl/writeback_arbiter.sv
// Sole register file writer: pipeline results win, queued M-unit results drain on idle pipe cycles.
// One-cycle registered write; M-unit backpressured only when the queue is full.
module writeback_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_arbiter_if.slave   bus
);
  import rv32_pkg::wb_entry_t;

  localparam int AW = $clog2(DEPTH);

  logic      pipe_sel;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;
  wb_entry_t head;
  wb_entry_t push_entry;

  assign pipe_sel      = bus.pipe_valid && (bus.pipe_rd != '0);
  assign bus.mdu_ready = !full && !rst;
  // Results for x0 are accepted and dropped so the M-unit never stalls on them.
  assign push          = bus.mdu_valid && bus.mdu_ready && (bus.mdu_rd != '0);
  assign pop           = !pipe_sel && !empty;
  assign push_entry    = '{rd: bus.mdu_rd, data: bus.mdu_data, live: 1'b1};

  wb_pending_queue #(.DEPTH(DEPTH)) u_queue (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_entry    (push_entry),
    .pop           (pop),
    .kill          (pipe_sel),
    .kill_rd       (bus.pipe_rd),
    .query_rd      (bus.query_rd),
    .query_pending (bus.query_pending),
    .head          (head),
    .count         (bus.fifo_count),
    .full          (full),
    .empty         (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.regWrite  <= 1'b0;
      bus.writeReg  <= '0;
      bus.writeData <= '0;
    end else if (pipe_sel) begin
      bus.regWrite  <= 1'b1;
      bus.writeReg  <= bus.pipe_rd;
      bus.writeData <= bus.pipe_data;
    end else if (pop && head.live) begin
      bus.regWrite  <= 1'b1;
      bus.writeReg  <= head.rd;
      bus.writeData <= head.data;
    end else begin
      bus.regWrite  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a queue-based reference model checked every cycle.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.XLEN(32), .DEPTH(DEPTH)) bus();

  writeback_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ment_t;

  ment_t       mq[$];
  ment_t       e;
  bit          model_on = 1'b0;
  bit          psel;
  bit          acc;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_wr = '0;
  logic [31:0] exp_wd = '0;
  logic [31:0] obs_rf [32];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: an ordered list of waiting results, updated once per rising edge.
  always @(posedge clk) begin
    model_on = 1'b1;
    if (rst) begin
      mq.delete();
      exp_we = 1'b0;
      exp_wr = '0;
      exp_wd = '0;
    end else begin
      psel = bus.pipe_valid && (bus.pipe_rd != 5'd0);
      acc  = bus.mdu_valid && (mq.size() < DEPTH);
      if (psel) begin
        foreach (mq[i]) if (mq[i].rd == bus.pipe_rd) mq[i].live = 1'b0;
        exp_we = 1'b1;
        exp_wr = bus.pipe_rd;
        exp_wd = bus.pipe_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        exp_we = e.live;
        if (e.live) begin
          exp_wr = e.rd;
          exp_wd = e.data;
        end
      end else begin
        exp_we = 1'b0;
      end
      if (acc && bus.mdu_rd != 5'd0)
        mq.push_back('{rd: bus.mdu_rd, data: bus.mdu_data,
                       live: !(psel && bus.pipe_rd == bus.mdu_rd)});
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("regWrite",      32'(bus.regWrite),      32'(exp_we));
      chk("writeReg",      32'(bus.writeReg),      32'(exp_wr));
      chk("writeData",     bus.writeData,          exp_wd);
      chk("fifo_count",    32'(bus.fifo_count),    32'(mq.size()));
      chk("mdu_ready",     32'(bus.mdu_ready),     32'(!rst && mq.size() < DEPTH));
      chk("query_pending", 32'(bus.query_pending), 32'(model_pending(bus.query_rd)));
      if (bus.regWrite) obs_rf[bus.writeReg] = bus.writeData;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.pipe_valid = 1'b0;
    bus.pipe_rd    = '0;
    bus.pipe_data  = '0;
    bus.mdu_valid  = 1'b1;
    bus.mdu_rd     = 5'd9;
    bus.mdu_data   = 32'hDEADBEEF;
    bus.query_rd   = '0;
    for (int i = 0; i < 32; i++) obs_rf[i] = '0;

    // Reset held two cycles with an M-unit offer pending
    tick; tick;
    chk("rst_ready",    32'(bus.mdu_ready),  0);
    chk("rst_we",       32'(bus.regWrite),   0);
    chk("rst_wr",       32'(bus.writeReg),   0);
    chk("rst_wd",       bus.writeData,       0);
    chk("rst_count",    32'(bus.fifo_count), 0);
    rst = 1'b0;
    bus.mdu_valid = 1'b0;

    // Pipe only, then pipe with rd=0
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_data = 32'hA5A5A5A5;
    tick;
    chk("pipe_we", 32'(bus.regWrite), 1);
    chk("pipe_wr", 32'(bus.writeReg), 1);
    chk("pipe_wd", bus.writeData, 32'hA5A5A5A5);
    bus.pipe_rd = 5'd0; bus.pipe_data = 32'hFFFFFFFF;
    tick;
    chk("x0_we",   32'(bus.regWrite), 0);
    chk("x0_hold", bus.writeData, 32'hA5A5A5A5);

    // Contention: MDU rd3 waits behind three pipe writes to rd5
    bus.pipe_rd = 5'd5; bus.pipe_data = 32'h55555555;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 32'h12345678;
    bus.query_rd = 5'd3;
    tick;
    chk("cont_wr0", 32'(bus.writeReg), 5);
    chk("cont_cnt", 32'(bus.fifo_count), 1);
    chk("cont_qp0", 32'(bus.query_pending), 1);
    bus.mdu_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      tick;
      chk("cont_wr5", 32'(bus.writeReg), 5);
      chk("cont_qp",  32'(bus.query_pending), 1);
    end
    bus.pipe_valid = 1'b0;
    tick;
    chk("cont_we3",  32'(bus.regWrite), 1);
    chk("cont_wr3",  32'(bus.writeReg), 3);
    chk("cont_wd3",  bus.writeData, 32'h12345678);
    chk("cont_qpx",  32'(bus.query_pending), 0);

    // Fill the queue while the pipe is busy, then drain
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5;
    bus.mdu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mdu_rd = 5'(10 + i); bus.mdu_data = 32'(100 + i);
      tick;
    end
    bus.mdu_valid = 1'b0;
    chk("full_cnt",   32'(bus.fifo_count), 4);
    chk("full_ready", 32'(bus.mdu_ready), 0);
    bus.pipe_valid = 1'b0;
    tick;
    chk("pop1_wr",    32'(bus.writeReg), 10);
    chk("pop1_wd",    bus.writeData, 100);
    chk("pop1_cnt",   32'(bus.fifo_count), 3);
    chk("pop1_ready", 32'(bus.mdu_ready), 1);
    for (int i = 1; i < 4; i++) begin
      tick;
      chk("drain_wr", 32'(bus.writeReg), 32'(10 + i));
    end
    chk("drain_cnt", 32'(bus.fifo_count), 0);

    // WAW kill of a queued entry
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'd1;
    tick;
    bus.mdu_valid = 1'b0;
    bus.pipe_rd = 5'd7; bus.pipe_data = 32'd2; bus.query_rd = 5'd7;
    tick;
    chk("waw_wd",  bus.writeData, 2);
    chk("waw_qp",  32'(bus.query_pending), 0);
    chk("waw_cnt", 32'(bus.fifo_count), 1);
    bus.pipe_valid = 1'b0;
    tick;
    chk("waw_pop_we", 32'(bus.regWrite), 0);
    chk("waw_rf7",    obs_rf[7], 2);

    // Push in the same cycle as a pipe write to the same rd
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd7; bus.pipe_data = 32'd4;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'd3;
    tick;
    chk("same_cnt", 32'(bus.fifo_count), 1);
    chk("same_qp",  32'(bus.query_pending), 0);
    bus.pipe_valid = 1'b0; bus.mdu_valid = 1'b0;
    tick;
    chk("same_we",  32'(bus.regWrite), 0);
    chk("same_rf7", obs_rf[7], 4);

    // M-unit result for x0 is consumed without queueing
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'd99;
    tick;
    chk("x0mdu_cnt", 32'(bus.fifo_count), 0);
    chk("x0mdu_we",  32'(bus.regWrite), 0);

    // Reset mid-drain, with a same-cycle push and pop just before
    bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5;
    for (int i = 0; i < 3; i++) begin
      bus.mdu_rd = 5'(20 + i); bus.mdu_data = 32'(200 + i);
      tick;
    end
    bus.pipe_valid = 1'b0; bus.mdu_rd = 5'd23; bus.mdu_data = 32'd203;
    tick;
    chk("pp_wr",  32'(bus.writeReg), 20);
    chk("pp_cnt", 32'(bus.fifo_count), 3);
    bus.mdu_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("mrst_we",    32'(bus.regWrite), 0);
    chk("mrst_cnt",   32'(bus.fifo_count), 0);
    chk("mrst_wr",    32'(bus.writeReg), 0);
    chk("mrst_ready", 32'(bus.mdu_ready), 0);
    rst = 1'b0;
    tick;
    chk("post_we",  32'(bus.regWrite), 0);
    chk("post_cnt", 32'(bus.fifo_count), 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
